march_addr_gen: RTL

//  Parametrised address sequencer for the memory BIST/BISR march engine; supersedes the fixed 16-bit free-running counter.

---
 rtl/march_pkg.sv | 6 +
 rtl/updown_cnt.sv | 22 ++
 rtl/march_addr_gen.sv | 96 +++++++++
 3 files changed

// File: rtl/march_pkg.sv
// Shared types and constants for the march BIST address sequencer.
package march_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
endpackage

// File: rtl/updown_cnt.sv
// Loadable up/down counter; load has priority over inc.
module updown_cnt
  import march_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          inc,
  input  logic          dir,
  output logic [AW-1:0] cnt
);
  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst)                 cnt <= '0;
    else if (load)           cnt <= load_val;
    else if (inc)            cnt <= (dir == DIR_DN) ? cnt - ONE : cnt + ONE;
  end
endmodule

// File: rtl/march_addr_gen.sv
// Window address sequencer for the march engine: start/busy/done handshake,
// abort, range-error and last-address flags.
module march_addr_gen
  import march_pkg::*;
#(
  parameter int AW          = 16,
  parameter int CLR_ON_IDLE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dir,
  input  logic [AW-1:0] lo_addr,
  input  logic [AW-1:0] hi_addr,
  input  logic          adv,
  input  logic          abort,
  output logic [AW-1:0] addr,
  output logic          addr_vld,
  output logic          last,
  output logic          busy,
  output logic          done,
  output logic          err
);
  state_t        state, nxt;
  logic [AW-1:0] end_q;
  logic          dir_q;
  logic          err_q;
  logic          load, inc;
  logic [AW-1:0] load_val;
  logic          range_ok, accept;

  assign range_ok = (lo_addr <= hi_addr);
  assign accept   = (state == ST_IDLE) && start && range_ok;

  always_comb begin
    nxt      = state;
    load     = 1'b0;
    load_val = '0;
    inc      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (range_ok) begin
            nxt      = ST_RUN;
            load     = 1'b1;
            load_val = (dir == DIR_DN) ? hi_addr : lo_addr;
          end
        end else if (CLR_ON_IDLE != 0) begin
          load = 1'b1;
        end
      end
      ST_RUN: begin
        // abort wins over adv; the address stays where it was
        if (abort)     nxt = ST_IDLE;
        else if (adv) begin
          if (last)    nxt = ST_DONE;
          else         inc = 1'b1;
        end
      end
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      err_q <= 1'b0;
      end_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      state <= nxt;
      err_q <= (state == ST_IDLE) && start && !range_ok;
      if (accept) begin
        end_q <= (dir == DIR_DN) ? lo_addr : hi_addr;
        dir_q <= dir;
      end
    end
  end

  updown_cnt #(.AW(AW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .inc      (inc),
    .dir      (dir_q),
    .cnt      (addr)
  );

  assign addr_vld = (state == ST_RUN);
  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);
  assign err      = err_q;
  assign last     = addr_vld && (addr == end_q);
endmodule
